// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU: registers decoded operands, forwards from
// MEM/WB onto them, selects immediate for B and inserts load-use bubbles.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic              id_uses_rt,
  input  logic [2:0]        id_aluop,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0] wb_wr_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_A,
  output logic [DATA_W-1:0] ex_B,
  output logic [2:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic              load_use_stall
);

  logic              valid_q,   valid_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic              use_imm_q, use_imm_d;
  logic [2:0]        aluop_q,   aluop_d;
  logic              wr_en_q,   wr_en_d;
  logic              is_load_q, is_load_d;

  logic              rs_hit, rt_hit;
  logic [DATA_W-1:0] src_rs, src_rt;

  // A load in EX cannot supply its result to the instruction right behind it.
  always_comb begin
    rs_hit = (id_rs_addr == rd_addr_q);
    rt_hit = id_uses_rt && (id_rt_addr == rd_addr_q);
    load_use_stall = valid_q && is_load_q && wr_en_q && (rd_addr_q != '0) &&
                     in_valid && (rs_hit || rt_hit);
  end

  always_comb begin
    valid_d   = in_valid;
    rs_addr_d = id_rs_addr;
    rt_addr_d = id_rt_addr;
    rd_addr_d = id_rd_addr;
    rs_data_d = id_rs_data;
    rt_data_d = id_rt_data;
    imm_d     = id_imm;
    use_imm_d = id_use_imm;
    aluop_d   = id_aluop;
    wr_en_d   = id_wr_en && in_valid;
    is_load_d = id_is_load && in_valid;
    // A bubble is exactly the reset content; stall wins over the load-use bubble.
    if (flush || (!stall && load_use_stall)) begin
      valid_d   = 1'b0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rd_addr_d = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      use_imm_d = 1'b0;
      aluop_d   = 3'b000;
      wr_en_d   = 1'b0;
      is_load_d = 1'b0;
    end else if (stall) begin
      valid_d   = valid_q;
      rs_addr_d = rs_addr_q;
      rt_addr_d = rt_addr_q;
      rd_addr_d = rd_addr_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      use_imm_d = use_imm_q;
      aluop_d   = aluop_q;
      wr_en_d   = wr_en_q;
      is_load_d = is_load_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      aluop_q   <= 3'b000;
      wr_en_q   <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      aluop_q   <= aluop_d;
      wr_en_q   <= wr_en_d;
      is_load_q <= is_load_d;
    end
  end

  // MEM is the younger producer, so it beats WB; r0 is never forwarded.
  always_comb begin
    if (mem_wr_en && (mem_wr_addr != '0) && (mem_wr_addr == rs_addr_q))
      src_rs = mem_wr_data;
    else if (wb_wr_en && (wb_wr_addr != '0) && (wb_wr_addr == rs_addr_q))
      src_rs = wb_wr_data;
    else
      src_rs = rs_data_q;

    if (mem_wr_en && (mem_wr_addr != '0) && (mem_wr_addr == rt_addr_q))
      src_rt = mem_wr_data;
    else if (wb_wr_en && (wb_wr_addr != '0) && (wb_wr_addr == rt_addr_q))
      src_rt = wb_wr_data;
    else
      src_rt = rt_data_q;
  end

  assign ex_valid      = valid_q;
  assign ex_A          = src_rs;
  assign ex_B          = use_imm_q ? imm_q : src_rt;
  assign ex_store_data = src_rt;
  assign ex_aluop      = aluop_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_wr_en      = wr_en_q && valid_q;
  assign ex_is_load    = is_load_q && valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of EX content.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, in_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm, id_uses_rt, id_wr_en, id_is_load;
  logic [2:0]  id_aluop;
  logic        mem_wr_en, wb_wr_en;
  logic [4:0]  mem_wr_addr, wb_wr_addr;
  logic [31:0] mem_wr_data, wb_wr_data;
  logic        ex_valid, ex_wr_en, ex_is_load, load_use_stall;
  logic [31:0] ex_A, ex_B, ex_store_data;
  logic [2:0]  ex_aluop;
  logic [4:0]  ex_rd_addr;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        useImm;
    logic [2:0]  op;
    logic        wr, ld;
  } exModel_t;

  exModel_t model;

  alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt),
    .id_aluop(id_aluop), .id_rd_addr(id_rd_addr), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_aluop(ex_aluop),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Value an operand should see after the MEM/WB bypass.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] regVal);
    if (mem_wr_en && mem_wr_addr != 0 && mem_wr_addr == a) return mem_wr_data;
    if (wb_wr_en && wb_wr_addr != 0 && wb_wr_addr == a) return wb_wr_data;
    return regVal;
  endfunction

  function automatic logic expLus();
    return model.valid && model.ld && model.wr && model.rd != 0 && in_valid &&
           (id_rs_addr == model.rd || (id_uses_rt && id_rt_addr == model.rd));
  endfunction

  function automatic exModel_t nextModel();
    exModel_t n;
    if (reset || flush) return '0;
    if (stall) return model;
    if (expLus()) return '0;
    n.valid = in_valid;
    n.rs = id_rs_addr; n.rt = id_rt_addr; n.rd = id_rd_addr;
    n.rsd = id_rs_data; n.rtd = id_rt_data; n.imm = id_imm;
    n.useImm = id_use_imm; n.op = id_aluop;
    n.wr = id_wr_en & in_valid; n.ld = id_is_load & in_valid;
    return n;
  endfunction

  task automatic checkAll(input string tag);
    logic [31:0] rtv;
    rtv = fwd(model.rt, model.rtd);
    checkOutput({tag, ".valid"}, {31'b0, ex_valid}, {31'b0, model.valid});
    checkOutput({tag, ".A"}, ex_A, fwd(model.rs, model.rsd));
    checkOutput({tag, ".B"}, ex_B, model.useImm ? model.imm : rtv);
    checkOutput({tag, ".store"}, ex_store_data, rtv);
    checkOutput({tag, ".aluop"}, {29'b0, ex_aluop}, {29'b0, model.op});
    checkOutput({tag, ".rd"}, {27'b0, ex_rd_addr}, {27'b0, model.rd});
    checkOutput({tag, ".wr"}, {31'b0, ex_wr_en}, {31'b0, model.wr & model.valid});
    checkOutput({tag, ".ld"}, {31'b0, ex_is_load}, {31'b0, model.ld & model.valid});
    checkOutput({tag, ".lus"}, {31'b0, load_use_stall}, {31'b0, expLus()});
  endtask

  // Called just after a negedge with inputs set: check, then cross one posedge.
  task automatic applyStimulus(input string tag);
    exModel_t n;
    #1;
    checkAll(tag);
    n = nextModel();
    @(posedge clk);
    model = n;
    @(negedge clk);
  endtask

  task automatic clearInputs();
    stall = 0; flush = 0; in_valid = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_use_imm = 0; id_uses_rt = 0; id_aluop = 0; id_wr_en = 0; id_is_load = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
    wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd,
                       input logic [2:0] op, input logic [4:0] rd, input logic ld);
    in_valid = 1; id_rs_addr = rs; id_rs_data = rsd; id_rt_addr = rt; id_rt_data = rtd;
    id_aluop = op; id_rd_addr = rd; id_wr_en = 1; id_is_load = ld;
  endtask

  initial begin
    clearInputs();
    reset = 1;
    model = '0;
    @(negedge clk);
    applyStimulus("reset");
    reset = 0;

    // Plain issue
    issue(5'd1, 32'h0000_0011, 5'd2, 32'hC000_0011, 3'b001, 5'd7, 0);
    applyStimulus("issue");
    clearInputs();
    #1;
    checkOutput("plain.A", ex_A, 32'h0000_0011);
    checkOutput("plain.B", ex_B, 32'hC000_0011);
    checkOutput("plain.aluop", {29'b0, ex_aluop}, 32'd1);
    checkOutput("plain.valid", {31'b0, ex_valid}, 32'd1);

    // Forwarding priority and r0 exclusion
    issue(5'd3, 32'h0000_AAAA, 5'd0, 32'h0, 3'b000, 5'd8, 0);
    applyStimulus("fwdIssue");
    clearInputs();
    mem_wr_en = 1; mem_wr_addr = 3; mem_wr_data = 32'h1234;
    wb_wr_en = 1; wb_wr_addr = 3; wb_wr_data = 32'h5678;
    #1 checkOutput("fwd.mem", ex_A, 32'h1234);
    mem_wr_en = 0;
    #1 checkOutput("fwd.wb", ex_A, 32'h5678);
    applyStimulus("fwdHold");
    issue(5'd0, 32'h0000_0099, 5'd0, 32'h0, 3'b000, 5'd8, 0);
    applyStimulus("r0Issue");
    clearInputs();
    mem_wr_en = 1; mem_wr_addr = 0; mem_wr_data = 32'h1234;
    wb_wr_en = 1; wb_wr_addr = 0; wb_wr_data = 32'h5678;
    #1 checkOutput("fwd.r0", ex_A, 32'h0000_0099);

    // Immediate selection versus store data
    clearInputs();
    issue(5'd1, 32'h1, 5'd4, 32'h7, 3'b000, 5'd9, 0);
    id_use_imm = 1; id_imm = 32'h0000_0001;
    applyStimulus("immIssue");
    clearInputs();
    mem_wr_en = 1; mem_wr_addr = 4; mem_wr_data = 32'hFFFF_FFFF;
    #1;
    checkOutput("imm.B", ex_B, 32'h0000_0001);
    checkOutput("imm.store", ex_store_data, 32'hFFFF_FFFF);
    clearInputs();

    // Load-use on rs
    issue(5'd1, 32'h10, 5'd2, 32'h20, 3'b000, 5'd5, 1);
    applyStimulus("loadIssue");
    clearInputs();
    issue(5'd5, 32'h0, 5'd6, 32'h0, 3'b011, 5'd10, 0);
    #1 checkOutput("lu.rs.stall", {31'b0, load_use_stall}, 32'd1);
    applyStimulus("luBubble");
    #1;
    checkOutput("lu.bubble.valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("lu.bubble.stall", {31'b0, load_use_stall}, 32'd0);
    applyStimulus("luRetry");
    clearInputs();

    // rt only matters when the instruction reads it
    issue(5'd1, 32'h10, 5'd2, 32'h20, 3'b000, 5'd5, 1);
    applyStimulus("loadIssue2");
    clearInputs();
    issue(5'd6, 32'h0, 5'd5, 32'h0, 3'b000, 5'd11, 0);
    #1 checkOutput("lu.rtUnused", {31'b0, load_use_stall}, 32'd0);
    id_uses_rt = 1;
    #1 checkOutput("lu.rtUsed", {31'b0, load_use_stall}, 32'd1);

    // Stall wins over the load-use bubble and freezes EX for three cycles
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_rs_data = $urandom;
      applyStimulus("stallHold");
      #1;
      checkOutput("stall.valid", {31'b0, ex_valid}, 32'd1);
      checkOutput("stall.ld", {31'b0, ex_is_load}, 32'd1);
      checkOutput("stall.rd", {27'b0, ex_rd_addr}, 32'd5);
      checkOutput("stall.lus", {31'b0, load_use_stall}, 32'd1);
    end
    flush = 1;
    applyStimulus("flushStall");
    #1;
    checkOutput("flush.valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("flush.rd", {27'b0, ex_rd_addr}, 32'd0);
    clearInputs();

    // Asynchronous reset between edges with EX full
    issue(5'd3, 32'hDEAD_BEEF, 5'd4, 32'hCAFE_F00D, 3'b101, 5'd12, 1);
    applyStimulus("preReset");
    clearInputs();
    #2 reset = 1;
    model = '0;
    #1;
    checkOutput("areset.valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("areset.A", ex_A, 32'd0);
    checkOutput("areset.B", ex_B, 32'd0);
    checkOutput("areset.store", ex_store_data, 32'd0);
    checkOutput("areset.ld", {31'b0, ex_is_load}, 32'd0);
    @(negedge clk);
    reset = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      id_rs_addr  = 5'($urandom_range(0, 7));
      id_rt_addr  = 5'($urandom_range(0, 7));
      id_rd_addr  = 5'($urandom_range(0, 7));
      id_rs_data  = $urandom;
      id_rt_data  = $urandom;
      id_imm      = $urandom;
      id_use_imm  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      id_aluop    = 3'($urandom_range(0, 5));
      id_wr_en    = ($urandom_range(0, 3) != 0);
      id_is_load  = ($urandom_range(0, 2) == 0);
      mem_wr_en   = 1'($urandom_range(0, 1));
      mem_wr_addr = 5'($urandom_range(0, 7));
      mem_wr_data = $urandom;
      wb_wr_en    = 1'($urandom_range(0, 1));
      wb_wr_addr  = 5'($urandom_range(0, 7));
      wb_wr_data  = $urandom;
      applyStimulus("rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
